// File: rtl/reg_file_sb_if.sv
// Issue / operand / writeback bundle for the scoreboarded register file.
// The master side drives requests, consumes operands and returns writebacks;
// the slave side is the register file itself.
interface reg_file_sb_if #(
  parameter int data_width = 8,
  parameter int addr_bits  = 3
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [addr_bits-1:0]  issue_rs0;
  logic [addr_bits-1:0]  issue_rs1;
  logic [addr_bits-1:0]  issue_rd;
  logic                  issue_wr;

  logic                  op_valid;
  logic                  op_ready;
  logic [data_width-1:0] op_a;
  logic [data_width-1:0] op_b;
  logic [addr_bits-1:0]  op_rd;
  logic                  op_wr;

  logic                  wb_en;
  logic [addr_bits-1:0]  wb_addr;
  logic [data_width-1:0] wb_data;

  modport master (
    output issue_valid, issue_rs0, issue_rs1, issue_rd, issue_wr,
    output op_ready, wb_en, wb_addr, wb_data,
    input  issue_ready, op_valid, op_a, op_b, op_rd, op_wr
  );

  modport slave (
    input  issue_valid, issue_rs0, issue_rs1, issue_rd, issue_wr,
    input  op_ready, wb_en, wb_addr, wb_data,
    output issue_ready, op_valid, op_a, op_b, op_rd, op_wr
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with busy-bit scoreboard and a one-entry operand stage.
// Issues stall on RAW/WAW hazards against outstanding writes; a writeback
// arriving in the same cycle as an issue is bypassed straight to the operand.

// n-way read mux: selects one width-bit word out of 2^sel_bits packed words.
module rf_mux #(
  parameter int width    = 8,
  parameter int sel_bits = 3
) (
  input  logic [(2**sel_bits)*width-1:0] data_in,
  input  logic [sel_bits-1:0]            sel,
  output logic [width-1:0]               data_out
);
  logic [width-1:0] words_s [2**sel_bits];

  // Split the packed input into addressable words.
  always_comb begin
    for (int i = 0; i < 2**sel_bits; i++) begin
      words_s[i] = data_in[i*width +: width];
    end
  end

  assign data_out = words_s[sel];
endmodule

module reg_file_sb #(
  parameter int data_width = 8,
  parameter int addr_bits  = 3
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int nreg = 2**addr_bits;
  localparam logic [addr_bits-1:0] zero_addr = {addr_bits{1'b0}};

  logic [nreg-1:0][data_width-1:0] regs_r;
  logic [nreg-1:0]                 busy_r;
  logic [nreg-1:0]                 busy_nxt_s;

  logic                  op_valid_r;
  logic [data_width-1:0] op_a_r;
  logic [data_width-1:0] op_b_r;
  logic [addr_bits-1:0]  op_rd_r;
  logic                  op_wr_r;

  logic [data_width-1:0] arr_a_s;
  logic [data_width-1:0] arr_b_s;
  logic [data_width-1:0] opnd_a_s;
  logic [data_width-1:0] opnd_b_s;
  logic                  wb_live_s;
  logic                  hit_a_s;
  logic                  hit_b_s;
  logic                  hit_rd_s;
  logic                  haz_a_s;
  logic                  haz_b_s;
  logic                  waw_s;
  logic                  issue_ready_s;
  logic                  accept_s;

  rf_mux #(.width(data_width), .sel_bits(addr_bits)) u_mux_a (
    .data_in  (regs_r),
    .sel      (bus.issue_rs0),
    .data_out (arr_a_s)
  );

  rf_mux #(.width(data_width), .sel_bits(addr_bits)) u_mux_b (
    .data_in  (regs_r),
    .sel      (bus.issue_rs1),
    .data_out (arr_b_s)
  );

  // Hazard detection and accept decision; a same-cycle writeback clears a hazard.
  always_comb begin
    wb_live_s     = bus.wb_en && (bus.wb_addr != zero_addr);
    hit_a_s       = wb_live_s && (bus.wb_addr == bus.issue_rs0);
    hit_b_s       = wb_live_s && (bus.wb_addr == bus.issue_rs1);
    hit_rd_s      = wb_live_s && (bus.wb_addr == bus.issue_rd);
    haz_a_s       = busy_r[bus.issue_rs0] && !hit_a_s;
    haz_b_s       = busy_r[bus.issue_rs1] && !hit_b_s;
    waw_s         = bus.issue_wr && (bus.issue_rd != zero_addr) &&
                    busy_r[bus.issue_rd] && !hit_rd_s;
    issue_ready_s = (!op_valid_r || bus.op_ready) && !haz_a_s && !haz_b_s && !waw_s;
    accept_s      = bus.issue_valid && issue_ready_s;
  end

  // Operand A selection: register 0 is hard zero, then bypass, then array.
  always_comb begin
    opnd_a_s = {data_width{1'b0}};
    if (bus.issue_rs0 == zero_addr) begin
      opnd_a_s = {data_width{1'b0}};
    end else if (hit_a_s) begin
      opnd_a_s = bus.wb_data;
    end else begin
      opnd_a_s = arr_a_s;
    end
  end

  // Operand B selection: register 0 is hard zero, then bypass, then array.
  always_comb begin
    opnd_b_s = {data_width{1'b0}};
    if (bus.issue_rs1 == zero_addr) begin
      opnd_b_s = {data_width{1'b0}};
    end else if (hit_b_s) begin
      opnd_b_s = bus.wb_data;
    end else begin
      opnd_b_s = arr_b_s;
    end
  end

  // Next busy vector: writeback clears first, an accepted write issue sets last.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wb_live_s) begin
      busy_nxt_s[bus.wb_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (accept_s && bus.issue_wr && (bus.issue_rd != zero_addr)) begin
      busy_nxt_s[bus.issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
  end

  // Register array and scoreboard state; register 0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_r <= '0;
      busy_r <= {nreg{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      if (wb_live_s) begin
        regs_r[bus.wb_addr] <= bus.wb_data;
      end else begin
        regs_r <= regs_r;
      end
    end
  end

  // Operand stage: load on accept, drain on consume, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_r <= 1'b0;
      op_a_r     <= {data_width{1'b0}};
      op_b_r     <= {data_width{1'b0}};
      op_rd_r    <= zero_addr;
      op_wr_r    <= 1'b0;
    end else if (accept_s) begin
      op_valid_r <= 1'b1;
      op_a_r     <= opnd_a_s;
      op_b_r     <= opnd_b_s;
      op_rd_r    <= bus.issue_rd;
      op_wr_r    <= bus.issue_wr;
    end else if (op_valid_r && bus.op_ready) begin
      op_valid_r <= 1'b0;
    end else begin
      op_valid_r <= op_valid_r;
    end
  end

  assign bus.issue_ready = issue_ready_s;
  assign bus.op_valid    = op_valid_r;
  assign bus.op_a        = op_a_r;
  assign bus.op_b        = op_b_r;
  assign bus.op_rd       = op_rd_r;
  assign bus.op_wr       = op_wr_r;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random
// traffic, all compared against a behavioural register/scoreboard model.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;

  reg_file_sb_if #(.data_width(8), .addr_bits(3)) bus ();

  reg_file_sb #(.data_width(8), .addr_bits(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [7:0] m_regs [8];
  bit         m_busy [8];
  bit         m_op_valid;
  logic [7:0] m_op_a, m_op_b;
  logic [2:0] m_op_rd;
  bit         m_op_wr;
  logic       seen_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00;
      m_busy[i] = 1'b0;
    end
    m_op_valid = 1'b0; m_op_a = 8'h00; m_op_b = 8'h00; m_op_rd = 3'd0; m_op_wr = 1'b0;
  endtask

  function automatic bit wb_hits(input logic [2:0] r);
    return bus.wb_en && (r != 3'd0) && (bus.wb_addr == r);
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] r);
    if (r == 3'd0) return 8'h00;
    if (wb_hits(r)) return bus.wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_haz(input logic [2:0] r);
    return m_busy[r] && !wb_hits(r);
  endfunction

  function automatic bit m_ready();
    return (!m_op_valid || bus.op_ready) && !m_haz(bus.issue_rs0) && !m_haz(bus.issue_rs1) &&
           !(bus.issue_wr && bus.issue_rd != 3'd0 && m_haz(bus.issue_rd));
  endfunction

  task automatic drive(input bit v, input logic [2:0] rs0, input logic [2:0] rs1,
                       input logic [2:0] rd, input bit wr, input bit ordy,
                       input bit wbe, input logic [2:0] wba, input logic [7:0] wbd);
    bus.issue_valid = v; bus.issue_rs0 = rs0; bus.issue_rs1 = rs1;
    bus.issue_rd = rd; bus.issue_wr = wr; bus.op_ready = ordy;
    bus.wb_en = wbe; bus.wb_addr = wba; bus.wb_data = wbd;
  endtask

  task automatic check_op(input string tag);
    check({tag, "_op_valid"}, bus.op_valid, m_op_valid);
    check({tag, "_op_a"}, bus.op_a, m_op_a);
    check({tag, "_op_b"}, bus.op_b, m_op_b);
    check({tag, "_op_rd"}, bus.op_rd, m_op_rd);
    check({tag, "_op_wr"}, bus.op_wr, m_op_wr);
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic cycle();
    bit rdy, acc;
    logic [7:0] a, b;
    #1;
    rdy = m_ready();
    seen_rdy = bus.issue_ready;
    check("issue_ready", bus.issue_ready, rdy);
    acc = bus.issue_valid && rdy;
    a = m_read(bus.issue_rs0);
    b = m_read(bus.issue_rs1);
    @(posedge clk);
    if (acc) begin
      m_op_valid = 1'b1; m_op_a = a; m_op_b = b;
      m_op_rd = bus.issue_rd; m_op_wr = bus.issue_wr;
    end else if (m_op_valid && bus.op_ready) begin
      m_op_valid = 1'b0;
    end
    if (bus.wb_en && bus.wb_addr != 3'd0) begin
      m_regs[bus.wb_addr] = bus.wb_data;
      m_busy[bus.wb_addr] = 1'b0;
    end
    if (acc && bus.issue_wr && bus.issue_rd != 3'd0) m_busy[bus.issue_rd] = 1'b1;
    #1;
    check_op("cyc");
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges; returns at a falling edge.
  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    m_reset();
    check_op("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] sv_a, sv_b;
  logic [2:0] sv_rd;
  bit         sv_wr;

  initial begin
    m_reset();
    drive(0, 3'd0, 3'd0, 3'd0, 0, 1, 0, 3'd0, 8'h00);
    #1;
    check_op("por");
    @(negedge clk);
    rst = 1'b1;

    // Reset then read
    drive(1, 3'd3, 3'd5, 3'd1, 1, 1, 0, 3'd0, 8'h00);
    cycle();
    check("t1_accept", seen_rdy, 1);
    check("t1_op_rd", bus.op_rd, 3'd1);
    drive(1, 3'd1, 3'd0, 3'd0, 0, 1, 0, 3'd0, 8'h00);
    cycle();
    check("t1_busy1_stall", seen_rdy, 0);

    // Writeback bypass then array read
    drive(1, 3'd2, 3'd0, 3'd0, 0, 1, 1, 3'd2, 8'hA5);
    cycle();
    check("t2_bypass_a", bus.op_a, 8'hA5);
    check("t2_b_zero", bus.op_b, 8'h00);
    drive(1, 3'd2, 3'd0, 3'd0, 0, 1, 0, 3'd0, 8'h00);
    cycle();
    check("t2_array_a", bus.op_a, 8'hA5);

    // RAW stall
    drive(1, 3'd0, 3'd0, 3'd4, 1, 1, 0, 3'd0, 8'h00);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd4, 3'd0, 3'd0, 0, 1, 0, 3'd0, 8'h00);
      cycle();
      check("t3_raw_stall", seen_rdy, 0);
    end
    drive(1, 3'd4, 3'd0, 3'd0, 0, 1, 1, 3'd4, 8'h3C);
    cycle();
    check("t3_raw_release", seen_rdy, 1);
    check("t3_bypass", bus.op_a, 8'h3C);

    // WAW stall and set-wins
    drive(1, 3'd0, 3'd0, 3'd6, 1, 1, 0, 3'd0, 8'h00);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1, 3'd0, 3'd0, 3'd6, 1, 1, 0, 3'd0, 8'h00);
      cycle();
      check("t4_waw_stall", seen_rdy, 0);
    end
    drive(1, 3'd0, 3'd0, 3'd6, 1, 1, 1, 3'd6, 8'h11);
    cycle();
    check("t4_waw_release", seen_rdy, 1);
    drive(1, 3'd6, 3'd0, 3'd0, 0, 1, 0, 3'd0, 8'h00);
    cycle();
    check("t4_set_wins", seen_rdy, 0);
    drive(0, 3'd0, 3'd0, 3'd0, 0, 1, 1, 3'd6, 8'h22);
    cycle();

    // Backpressure
    drive(1, 3'd2, 3'd5, 3'd7, 0, 1, 0, 3'd0, 8'h00);
    cycle();
    sv_a = bus.op_a; sv_b = bus.op_b; sv_rd = bus.op_rd; sv_wr = bus.op_wr;
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd2, 3'd2, 3'd0, 0, 0, 0, 3'd0, 8'h00);
      cycle();
      check("t5_bp_stall", seen_rdy, 0);
      check("t5_hold_a", bus.op_a, sv_a);
      check("t5_hold_b", bus.op_b, sv_b);
      check("t5_hold_rd", bus.op_rd, sv_rd);
      check("t5_hold_wr", bus.op_wr, sv_wr);
    end
    drive(1, 3'd5, 3'd2, 3'd7, 1, 1, 0, 3'd0, 8'h00);
    cycle();
    check("t5_b2b_accept", seen_rdy, 1);
    check("t5_b2b_valid", bus.op_valid, 1);
    check("t5_b2b_wr", bus.op_wr, 1);

    // Register 0 ignores writes
    drive(0, 3'd0, 3'd0, 3'd0, 0, 1, 1, 3'd0, 8'hFF);
    cycle();
    drive(1, 3'd0, 3'd0, 3'd0, 0, 1, 0, 3'd0, 8'h00);
    cycle();
    check("t6_r0_zero", bus.op_a, 8'h00);

    // Mid-operation reset
    drive(1, 3'd0, 3'd0, 3'd3, 1, 1, 0, 3'd0, 8'h00);
    cycle();
    drive(0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 8'h00);
    cycle();
    check("t7_pending", bus.op_valid, 1);
    do_reset();
    drive(1, 3'd3, 3'd0, 3'd0, 0, 1, 0, 3'd0, 8'h00);
    cycle();
    check("t7_post_rst_accept", seen_rdy, 1);
    check("t7_post_rst_valid", bus.op_valid, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
            3'($urandom_range(7, 0)), $urandom_range(1, 0) == 1, $urandom_range(9, 0) < 7,
            $urandom_range(9, 0) < 4, 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
      cycle();
      if (i == 200) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Register file with a busy-bit scoreboard and a one-entry operand output stage. It accepts an issue request naming two source registers and an optional destination, and stalls on RAW/WAW hazards against outstanding writes. It delivers the two operands to the execute stage over a valid/ready handshake. It takes writebacks from execute. Read paths are built from the team's n-way Mux primitive, with addr_bits select bits.

## Interface
- data_width, 8, register and operand width
- addr_bits, 3, register address width; register count = 2^addr_bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  issue request present
- issue_ready  out  1  issue request accepted this cycle when issue_valid=1
- issue_rs0  in  addr_bits  source A register
- issue_rs1  in  addr_bits  source B register
- issue_rd  in  addr_bits  destination register
- issue_wr  in  1  instruction writes issue_rd
- op_valid  out  1  operand stage holds a valid entry
- op_ready  in  1  execute consumes entry this cycle when op_valid=1
- op_a, op_b  out  data_width  source operands
- op_rd  out  addr_bits  destination, passed through
- op_wr  out  1  write flag, passed through
- wb_en  in  1  writeback strobe
- wb_addr  in  addr_bits  writeback register
- wb_data  in  data_width  writeback data

## Operation
- Register 0 always reads 0. Writes to it are ignored, and it is never marked busy.
- busy[i] is set when an issue with issue_wr=1 and issue_rd=i≠0 is accepted. It is cleared by wb_en with wb_addr=i.
- Hazard for source s: busy[s]=1, unless wb_en=1 and wb_addr=s in the same cycle. In that case wb_data is bypassed and there is no hazard.
- WAW hazard: issue_wr=1, issue_rd≠0, busy[issue_rd]=1 and not cleared by a same-cycle wb.
- issue_ready = (~op_valid | op_ready) & no hazard on rs0 & no hazard on rs1 & no WAW hazard.
- issue_ready depends on the issue fields, state and wb inputs. It never depends on issue_valid.
- On accept, the operand stage loads:
  - op_a/op_b = bypassed wb_data if wb_en=1 and wb_addr matches, else register contents; 0 for register 0.
  - op_rd = issue_rd, op_wr = issue_wr.
  - op_valid = 1.
- Operand stage:
  - op_valid & ~op_ready: all op_* outputs hold stable.
  - op_valid & op_ready & no accept: op_valid → 0; data outputs hold their last value.
  - op_ready & accept in the same cycle: new entry loads with no bubble.
- Writeback:
  - wb_en to a non-busy register is legal. Data is written, busy stays 0.
  - wb_en with wb_addr=0 has no effect.
- Same-cycle wb clear and issue set of the same register: set wins, so busy=1 and the register holds wb_data.
- Writeback is never stalled; there is no ready on the wb port.

## Timing
- Reset asserted (asynchronous): all registers, all busy bits, op_valid, op_a, op_b, op_rd and op_wr go to 0 immediately.
- Reset asserted mid-operation: any pending operand entry and all scoreboard state are discarded. No output glitches past reset deassertion.
- First accept is possible on the first rising edge after reset deassertion.
- Issue-to-operand latency: accept at edge N puts op_valid=1 with operands after edge N.
- Writeback-to-read:
  - Data written at edge N is visible to an issue accepted at edge N via bypass.
  - It is visible from the array for issues accepted at N+1 onward.
- Throughput: one issue per cycle when op_ready=1 and there are no hazards.
- The only combinational paths are issue fields/wb/op_ready → issue_ready. There is no path from op_ready to op_*.

## Test plan
- Reset then read: after reset, issue rs0=3, rs1=5, rd=1, wr=1 → issue_ready=1; next cycle op_valid=1, op_a=0, op_b=0, op_rd=1, op_wr=1; busy[1]=1.
- Writeback then issue: wb_en addr=2 data=0xA5, and in the same cycle issue rs0=2, rs1=0 → accepted with op_a=0xA5 (bypass), op_b=0. The following issue rs0=2 reads 0xA5 from the array.
- RAW stall:
  - Issue rd=4 wr=1 is accepted, then issue rs0=4 → issue_ready=0 for 3 cycles.
  - wb addr=4 data=0x3C → accepted in the wb cycle with op_a=0x3C.
- WAW stall and set-wins:
  - Stall: with busy[6]=1, issue rd=6 wr=1 → issue_ready=0 until wb addr=6.
  - Set-wins: in the same cycle as that wb, issue rd=6 is accepted → busy[6]=1 afterward.
- Backpressure: op_ready=0 with op_valid=1 → op_a/op_b/op_rd/op_wr stable and issue_ready=0 for 5 cycles. Raising op_ready with issue_valid=1 → back-to-back transfer, op_valid stays 1.
- Register 0 and mid-op reset:
  - wb addr=0 data=0xFF, then issue rs0=0 → op_a=0.
  - With busy[3]=1 and op_valid=1, pulse rst low → op_valid=0 and busy cleared. Issue rs0=3 is accepted on the first edge after release.
